// File: rtl/vec_instr_dispatch_q.sv
// Circular instruction queue that dispatches its head entry to one of NUM_CH channels by an ID field.
// Optional macro VEC_IQ_BYPASS_EN adds a same-cycle path from control_* to ch_* when the queue is empty.
module vec_instr_dispatch_q #(
  parameter int DATA_WIDTH      = 64,
  parameter int VEC_INSTR_WIDTH = 32,
  parameter int INSTR_WIDTH     = 3*DATA_WIDTH-VEC_INSTR_WIDTH,
  parameter int DEPTH           = 10,
  parameter int NUM_CH          = 2,
  parameter int CH_BITS         = 1,
  parameter int AFULL_THRESH    = 8
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           flush,
  input  logic                           control_wr,
  input  logic [INSTR_WIDTH-1:0]         control_data,
  output logic                           core_busy,
  output logic                           almost_full,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic [NUM_CH-1:0]              ch_valid,
  input  logic [NUM_CH-1:0]              ch_ready,
  output logic [INSTR_WIDTH-CH_BITS-1:0] ch_data,
  output logic                           overflow,
  output logic                           bad_ch
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PL_W  = INSTR_WIDTH-CH_BITS;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH-1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Out-of-range IDs decode to all-zero, which is how a bad channel is detected.
  function automatic logic [NUM_CH-1:0] ch_decode(input logic [CH_BITS-1:0] id);
    logic [NUM_CH-1:0] oh;
    oh = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (id == CH_BITS'(i)) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_overflow;
  logic                   r_bad_ch;

  logic [INSTR_WIDTH-1:0] w_head;
  logic [NUM_CH-1:0]      w_head_oh;
  logic                   w_nonempty;
  logic                   w_full;
  logic                   w_head_bad;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_wr;
  logic                   w_bad_evt;

  // Head decode, pop and accepted-push qualification from registered state.
  always_comb begin
    w_head     = r_mem[r_rd_ptr];
    w_nonempty = (r_count != {CNT_W{1'b0}});
    w_full     = (r_count == CNT_W'(DEPTH));
    w_push     = control_wr && !w_full && !flush && !RESET;
    if (w_nonempty) begin
      w_head_oh = ch_decode(w_head[INSTR_WIDTH-1 -: CH_BITS]);
    end else begin
      w_head_oh = {NUM_CH{1'b0}};
    end
    w_head_bad = w_nonempty && (w_head_oh == {NUM_CH{1'b0}});
    w_pop      = w_head_bad || (|(w_head_oh & ch_ready));
  end

`ifdef VEC_IQ_BYPASS_EN
  logic [NUM_CH-1:0] w_byp_oh;

  // An empty queue forwards the incoming push straight to the channels.
  always_comb begin
    w_byp_oh = ch_decode(control_data[INSTR_WIDTH-1 -: CH_BITS]);
    if (w_push && !w_nonempty) begin
      ch_valid  = w_byp_oh;
      ch_data   = control_data[PL_W-1:0];
      w_wr      = (w_byp_oh != {NUM_CH{1'b0}}) && !(|(w_byp_oh & ch_ready));
      w_bad_evt = (w_byp_oh == {NUM_CH{1'b0}});
    end else begin
      ch_valid  = w_head_oh;
      ch_data   = w_head[PL_W-1:0];
      w_wr      = w_push;
      w_bad_evt = w_head_bad;
    end
  end
`else
  // Channel outputs come only from the stored head entry.
  always_comb begin
    ch_valid  = w_head_oh;
    ch_data   = w_head[PL_W-1:0];
    w_wr      = w_push;
    w_bad_evt = w_head_bad;
  end
`endif

  // Status flags derived from the registered count.
  always_comb begin
    core_busy   = w_full;
    almost_full = (r_count >= CNT_W'(AFULL_THRESH));
    occupancy   = r_count;
    overflow    = r_overflow;
    bad_ch      = r_bad_ch;
  end

  // Pointers, count and sticky flags; reset outranks flush, flush outranks traffic.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
      r_bad_ch   <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_wr) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (control_wr && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_bad_evt) begin
        r_bad_ch <= 1'b1;
      end
    end
  end

  // Entry storage is deliberately left uninitialised.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= control_data;
    end
  end

endmodule

// File: tb/tb_vec_instr_dispatch_q.sv
// Scoreboard bench for vec_instr_dispatch_q: default 2-channel instance plus a 3-channel instance.
module tb_vec_instr_dispatch_q;

  typedef struct packed {
    logic [1:0]   oh;
    logic [158:0] pl;
  } ent_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RESET = 1'b1;
  logic         flush = 1'b0;
  logic         a_wr = 1'b0;
  logic [159:0] a_data = 160'd0;
  logic [1:0]   a_ready = 2'b00;
  logic         a_busy, a_afull, a_ovf, a_bad;
  logic [3:0]   a_occ;
  logic [1:0]   a_valid;
  logic [158:0] a_chd;

  logic         b_wr = 1'b0;
  logic [159:0] b_data = 160'd0;
  logic [2:0]   b_ready = 3'b000;
  logic         b_busy, b_afull, b_ovf, b_bad;
  logic [3:0]   b_occ;
  logic [2:0]   b_valid;
  logic [157:0] b_chd;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t sb[$];

  vec_instr_dispatch_q u_dut_a (
    .CLK(CLK), .RESET(RESET), .flush(flush), .control_wr(a_wr), .control_data(a_data),
    .core_busy(a_busy), .almost_full(a_afull), .occupancy(a_occ), .ch_valid(a_valid),
    .ch_ready(a_ready), .ch_data(a_chd), .overflow(a_ovf), .bad_ch(a_bad)
  );

  vec_instr_dispatch_q #(.NUM_CH(3), .CH_BITS(2)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .flush(1'b0), .control_wr(b_wr), .control_data(b_data),
    .core_busy(b_busy), .almost_full(b_afull), .occupancy(b_occ), .ch_valid(b_valid),
    .ch_ready(b_ready), .ch_data(b_chd), .overflow(b_ovf), .bad_ch(b_bad)
  );

  task automatic drive_a(input logic ch, input bit keep);
    ent_t e;
    e.oh = ch ? 2'b10 : 2'b01;
    e.pl = 159'({$urandom, $urandom, $urandom, $urandom, $urandom});
    if (keep) sb.push_back(e);
    a_data = {ch, e.pl};
    a_wr   = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_afull !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b want 0", a_afull); end
    n_cmp++; if (a_occ !== 4'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", a_occ); end
    n_cmp++; if (a_valid !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b want 00", a_valid); end
    n_cmp++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", a_ovf); end
    n_cmp++; if (a_bad !== 1'b0) begin n_err++; $display("FAIL reset_bad: got %b want 0", a_bad); end
    n_cmp++; if (b_valid !== 3'b000) begin n_err++; $display("FAIL reset_b_valid: got %b want 000", b_valid); end
    RESET = 1'b0;
    sb.delete();
  endtask

  task automatic test_stream();
    a_ready = 2'b11;
`ifdef VEC_IQ_BYPASS_EN
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge CLK);
      n_cmp++; if (a_occ !== 4'd0) begin n_err++; $display("FAIL stream_occ: cyc %0d got %0d want 0", cyc, a_occ); end
      drive_a(cyc[0], 1'b1);
      #1;
      n_cmp++; if (a_valid !== sb[0].oh) begin n_err++; $display("FAIL stream_valid: cyc %0d got %b want %b", cyc, a_valid, sb[0].oh); end
      n_cmp++; if (a_chd !== sb[0].pl) begin n_err++; $display("FAIL stream_data: cyc %0d got %h want %h", cyc, a_chd, sb[0].pl); end
      void'(sb.pop_front());
    end
    @(negedge CLK);
    a_wr = 1'b0;
`else
    for (int cyc = 0; cyc <= 10; cyc++) begin
      @(negedge CLK);
      if (cyc > 0) begin
        n_cmp++; if (a_occ !== 4'd1) begin n_err++; $display("FAIL stream_occ: cyc %0d got %0d want 1", cyc, a_occ); end
        n_cmp++; if (a_valid !== sb[0].oh) begin n_err++; $display("FAIL stream_valid: cyc %0d got %b want %b", cyc, a_valid, sb[0].oh); end
        n_cmp++; if (a_chd !== sb[0].pl) begin n_err++; $display("FAIL stream_data: cyc %0d got %h want %h", cyc, a_chd, sb[0].pl); end
        void'(sb.pop_front());
      end
      if (cyc < 10) begin
        drive_a(cyc[0], 1'b1);
        #1;
        if (cyc == 0) begin
          n_cmp++; if (a_valid !== 2'b00) begin n_err++; $display("FAIL stream_latency: got %b want 00", a_valid); end
        end
      end else begin
        a_wr = 1'b0;
      end
    end
`endif
    @(negedge CLK);
    n_cmp++; if (a_occ !== 4'd0) begin n_err++; $display("FAIL stream_empty_occ: got %0d want 0", a_occ); end
    n_cmp++; if (a_valid !== 2'b00) begin n_err++; $display("FAIL stream_empty_valid: got %b want 00", a_valid); end
  endtask

  task automatic test_hol_blocking();
    a_ready = 2'b01;
    @(negedge CLK); drive_a(1'b1, 1'b1);
    @(negedge CLK); drive_a(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      a_wr = 1'b0;
      n_cmp++; if (a_valid !== 2'b10) begin n_err++; $display("FAIL hol_valid: cyc %0d got %b want 10", i, a_valid); end
      n_cmp++; if (a_occ !== 4'd2) begin n_err++; $display("FAIL hol_occ: cyc %0d got %0d want 2", i, a_occ); end
    end
    n_cmp++; if (a_chd !== sb[0].pl) begin n_err++; $display("FAIL hol_data1: got %h want %h", a_chd, sb[0].pl); end
    void'(sb.pop_front());
    a_ready = 2'b11;
    @(negedge CLK);
    n_cmp++; if (a_valid !== 2'b01) begin n_err++; $display("FAIL hol_valid0: got %b want 01", a_valid); end
    n_cmp++; if (a_chd !== sb[0].pl) begin n_err++; $display("FAIL hol_data0: got %h want %h", a_chd, sb[0].pl); end
    void'(sb.pop_front());
    @(negedge CLK);
    n_cmp++; if (a_occ !== 4'd0) begin n_err++; $display("FAIL hol_drained: got %0d want 0", a_occ); end
  endtask

  task automatic test_fill_overflow();
    a_ready = 2'b00;
    n_cmp++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL fill_ovf_pre: got %b want 0", a_ovf); end
    for (int k = 0; k <= 11; k++) begin
      @(negedge CLK);
      if (k > 0) begin
        n_cmp++; if (a_occ !== 4'((k > 10) ? 10 : k)) begin n_err++; $display("FAIL fill_occ: step %0d got %0d", k, a_occ); end
        n_cmp++; if (a_afull !== (k >= 8)) begin n_err++; $display("FAIL fill_afull: step %0d got %b want %b", k, a_afull, (k >= 8)); end
        n_cmp++; if (a_busy !== (k >= 10)) begin n_err++; $display("FAIL fill_busy: step %0d got %b want %b", k, a_busy, (k >= 10)); end
      end
      if (k < 11) drive_a(k[0], (k < 10));
      else a_wr = 1'b0;
    end
    n_cmp++; if (a_ovf !== 1'b1) begin n_err++; $display("FAIL fill_ovf: got %b want 1", a_ovf); end
    a_ready = 2'b11;
    for (int k = 0; k < 10; k++) begin
      n_cmp++; if (a_valid !== sb[0].oh) begin n_err++; $display("FAIL drain_valid: idx %0d got %b want %b", k, a_valid, sb[0].oh); end
      n_cmp++; if (a_chd !== sb[0].pl) begin n_err++; $display("FAIL drain_data: idx %0d got %h want %h", k, a_chd, sb[0].pl); end
      void'(sb.pop_front());
      @(negedge CLK);
    end
    n_cmp++; if (a_occ !== 4'd0) begin n_err++; $display("FAIL drain_occ: got %0d want 0", a_occ); end
    n_cmp++; if (a_valid !== 2'b00) begin n_err++; $display("FAIL drain_valid_end: got %b want 00", a_valid); end
  endtask

  task automatic test_bad_channel();
    logic [157:0] pl3, pl2;
    pl3 = 158'({$urandom, $urandom, $urandom, $urandom, $urandom});
    pl2 = 158'({$urandom, $urandom, $urandom, $urandom, $urandom});
    b_ready = 3'b000;
    n_cmp++; if (b_bad !== 1'b0) begin n_err++; $display("FAIL bad_pre: got %b want 0", b_bad); end
    @(negedge CLK);
    b_data = {2'd3, pl3};
    b_wr   = 1'b1;
    @(negedge CLK);
    n_cmp++; if (b_valid !== 3'b000) begin n_err++; $display("FAIL bad_valid: got %b want 000", b_valid); end
    b_data = {2'd2, pl2};
    @(negedge CLK);
    b_wr = 1'b0;
    n_cmp++; if (b_valid !== 3'b100) begin n_err++; $display("FAIL bad_next_valid: got %b want 100", b_valid); end
    n_cmp++; if (b_chd !== pl2) begin n_err++; $display("FAIL bad_next_data: got %h want %h", b_chd, pl2); end
    n_cmp++; if (b_bad !== 1'b1) begin n_err++; $display("FAIL bad_sticky: got %b want 1", b_bad); end
    n_cmp++; if (b_occ !== 4'd1) begin n_err++; $display("FAIL bad_occ: got %0d want 1", b_occ); end
    b_ready = 3'b100;
    @(negedge CLK);
    n_cmp++; if (b_occ !== 4'd0) begin n_err++; $display("FAIL bad_drain: got %0d want 0", b_occ); end
    n_cmp++; if (b_bad !== 1'b1) begin n_err++; $display("FAIL bad_hold: got %b want 1", b_bad); end
  endtask

  task automatic test_latency();
    a_ready = 2'b01;
    @(negedge CLK);
    drive_a(1'b0, 1'b1);
    #1;
`ifdef VEC_IQ_BYPASS_EN
    n_cmp++; if (a_valid !== 2'b01) begin n_err++; $display("FAIL byp_valid: got %b want 01", a_valid); end
    n_cmp++; if (a_chd !== sb[0].pl) begin n_err++; $display("FAIL byp_data: got %h want %h", a_chd, sb[0].pl); end
    void'(sb.pop_front());
    @(negedge CLK);
    n_cmp++; if (a_occ !== 4'd0) begin n_err++; $display("FAIL byp_occ: got %0d want 0", a_occ); end
    a_ready = 2'b00;
    drive_a(1'b0, 1'b1);
    #1;
    n_cmp++; if (a_valid !== 2'b01) begin n_err++; $display("FAIL byp_stall_valid: got %b want 01", a_valid); end
    @(negedge CLK);
    a_wr = 1'b0;
    n_cmp++; if (a_occ !== 4'd1) begin n_err++; $display("FAIL byp_stored_occ: got %0d want 1", a_occ); end
    #1;
    n_cmp++; if (a_chd !== sb[0].pl) begin n_err++; $display("FAIL byp_stored_data: got %h want %h", a_chd, sb[0].pl); end
    a_ready = 2'b01;
    void'(sb.pop_front());
`else
    n_cmp++; if (a_valid !== 2'b00) begin n_err++; $display("FAIL lat_comb_path: got %b want 00", a_valid); end
    @(negedge CLK);
    a_wr = 1'b0;
    n_cmp++; if (a_valid !== 2'b01) begin n_err++; $display("FAIL lat_valid: got %b want 01", a_valid); end
    n_cmp++; if (a_occ !== 4'd1) begin n_err++; $display("FAIL lat_occ: got %0d want 1", a_occ); end
    n_cmp++; if (a_chd !== sb[0].pl) begin n_err++; $display("FAIL lat_data: got %h want %h", a_chd, sb[0].pl); end
    void'(sb.pop_front());
`endif
    @(negedge CLK);
    n_cmp++; if (a_occ !== 4'd0) begin n_err++; $display("FAIL lat_drain: got %0d want 0", a_occ); end
  endtask

  task automatic test_full_flush_reset();
    a_ready = 2'b00;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      drive_a(k[0], 1'b1);
    end
    @(negedge CLK);
    n_cmp++; if (a_occ !== 4'd10) begin n_err++; $display("FAIL full_occ: got %0d want 10", a_occ); end
    n_cmp++; if (a_chd !== sb[0].pl) begin n_err++; $display("FAIL full_head: got %h want %h", a_chd, sb[0].pl); end
    void'(sb.pop_front());
    drive_a(1'b0, 1'b0);
    a_ready = 2'b11;
    @(negedge CLK);
    a_wr = 1'b0;
    n_cmp++; if (a_occ !== 4'd9) begin n_err++; $display("FAIL full_pushpop_occ: got %0d want 9", a_occ); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (a_chd !== sb[0].pl) begin n_err++; $display("FAIL full_drain_data: idx %0d got %h want %h", k, a_chd, sb[0].pl); end
      void'(sb.pop_front());
      @(negedge CLK);
    end
    n_cmp++; if (a_occ !== 4'd5) begin n_err++; $display("FAIL pre_flush_occ: got %0d want 5", a_occ); end
    flush   = 1'b1;
    a_ready = 2'b00;
    drive_a(1'b1, 1'b0);
    @(negedge CLK);
    n_cmp++; if (a_occ !== 4'd0) begin n_err++; $display("FAIL flush_occ: got %0d want 0", a_occ); end
    n_cmp++; if (a_valid !== 2'b00) begin n_err++; $display("FAIL flush_valid: got %b want 00", a_valid); end
    n_cmp++; if (a_ovf !== 1'b1) begin n_err++; $display("FAIL flush_ovf_kept: got %b want 1", a_ovf); end
    flush = 1'b0;
    a_wr  = 1'b0;
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      drive_a(k[0], 1'b1);
    end
    @(negedge CLK);
    a_wr    = 1'b0;
    a_ready = 2'b11;
    @(negedge CLK);
    n_cmp++; if (a_occ !== 4'd2) begin n_err++; $display("FAIL mid_drain_occ: got %0d want 2", a_occ); end
    RESET = 1'b1;
    drive_a(1'b0, 1'b0);
    @(negedge CLK);
    n_cmp++; if (a_occ !== 4'd0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", a_occ); end
    n_cmp++; if (a_valid !== 2'b00) begin n_err++; $display("FAIL rst_valid: got %b want 00", a_valid); end
    n_cmp++; if (a_busy !== 1'b0 || a_afull !== 1'b0) begin n_err++; $display("FAIL rst_flags: got %b%b want 00", a_busy, a_afull); end
    n_cmp++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", a_ovf); end
    n_cmp++; if (b_bad !== 1'b0) begin n_err++; $display("FAIL rst_b_bad: got %b want 0", b_bad); end
    RESET = 1'b0;
    a_wr  = 1'b0;
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hol_blocking();
    test_fill_overflow();
    test_bad_channel();
    test_latency();
    test_full_flush_reset();
    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
